// File: rtl/regfile_param.sv
// regfile_param: parametrised integer register file for the decode/writeback stages.
//
// Storage is DEPTH x DATA_W flops with no reset on the array. A clear sequencer zeroes
// every entry after reset and on a one-cycle clear request. While it runs, ready_o is
// low, writes are dropped and every read port returns zero.
//
// Parameters:
//   DATA_W   entry width in bits
//   DEPTH    number of entries (2..256, need not be a power of two)
//   NUM_RD   number of combinational read ports (1..4)
//   ZERO_REG when 1, entry 0 always reads 0 and ignores writes
//   ADDR_W   derived address width, not meant to be overridden
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; restarts the clear sweep
//   clear_i    one-cycle request to re-zero all entries (ignored while sweeping)
//   ready_o    high when writes are accepted and stored data is returned
//   w_en_i     write enable
//   w_addr_i   write address
//   w_data_i   write data, stored unmodified
//   r_addr_i   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   r_data_o   packed read data, port k at [k*DATA_W +: DATA_W]
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, an accepted write is forwarded to any read port
//                      addressing the same entry in the same cycle. When undefined, a
//                      same-cycle read returns the pre-write contents.

module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    output logic                       ready_o,
    input  logic                       w_en_i,
    input  logic [ADDR_W-1:0]          w_addr_i,
    input  logic [DATA_W-1:0]          w_data_i,
    input  logic [NUM_RD*ADDR_W-1:0]   r_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   r_data_o
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
        $error("regfile_param: DEPTH must be within 2..256");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_param: NUM_RD must be within 1..4");
    end

    // Sequencer states.
    localparam logic [0:0] StInit  = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DepthLim  = (ADDR_W + 1)'(DEPTH);
    // With a power-of-two depth every address is in range, so no compare is built.
    localparam bit                FullDepth = (DEPTH == (1 << ADDR_W));
    localparam bit                ZeroEn    = (ZERO_REG != 0);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic w_in_range;
    logic w_accept;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StInit: begin
                // The last entry is cleared on the same edge that enters READY.
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StReady: begin
                if (clear_i) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready_o = (state_q == StReady);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    if (FullDepth) begin : g_w_full
        assign w_in_range = 1'b1;
    end else begin : g_w_part
        assign w_in_range = ({1'b0, w_addr_i} < DepthLim);
    end

    // A clear request in READY takes priority: the colliding write is lost.
    assign w_accept = ready_o && w_en_i && !clear_i && w_in_range
                      && !(ZeroEn && (w_addr_i == '0));

    // The array has no reset; the sweep provides the defined contents.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem_q[cnt_q] <= '0;
        end else if (w_accept) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              ra_ok;
        logic [DATA_W-1:0] rd;

        assign ra = r_addr_i[k*ADDR_W +: ADDR_W];

        if (FullDepth) begin : g_full
            assign ra_ok = 1'b1;
        end else begin : g_part
            assign ra_ok = ({1'b0, ra} < DepthLim);
        end

        always_comb begin
            rd = '0;
            if (ready_o && ra_ok && !(ZeroEn && (ra == '0))) begin
                rd = mem_q[ra];
            end
`ifdef REGFILE_BYPASS_EN
            // w_accept already excludes dropped writes, so nothing bogus is forwarded.
            if (w_accept && (ra == w_addr_i)) begin
                rd = w_data_i;
            end
`endif
        end

        assign r_data_o[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: a default instance (32 x 32, 2 ports) and a
// non-power-of-two instance (24 entries, 3 ports). Expected values are queued when the
// stimulus is applied and compared when the outputs are sampled.

module tb_regfile_param;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Default instance.
    logic        clear, ready, w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [9:0]  r_addr;
    logic [63:0] r_data;

    // DEPTH=24, NUM_RD=3 instance.
    logic        b_clear, b_ready, b_w_en;
    logic [4:0]  b_w_addr;
    logic [31:0] b_w_data;
    logic [14:0] b_r_addr;
    logic [95:0] b_r_data;

    regfile_param #(
        .DATA_W  (32),
        .DEPTH   (32),
        .NUM_RD  (2),
        .ZERO_REG(1)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .ready_o (ready),
        .w_en_i  (w_en),
        .w_addr_i(w_addr),
        .w_data_i(w_data),
        .r_addr_i(r_addr),
        .r_data_o(r_data)
    );

    regfile_param #(
        .DATA_W  (32),
        .DEPTH   (24),
        .NUM_RD  (3),
        .ZERO_REG(1)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .clear_i (b_clear),
        .ready_o (b_ready),
        .w_en_i  (b_w_en),
        .w_addr_i(b_w_addr),
        .w_data_i(b_w_data),
        .r_addr_i(b_r_addr),
        .r_data_o(b_r_data)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    // Counts 32 edges after a reset release or a sampled clear. The default instance must
    // rise only on the 32nd edge; the small instance on its 24th if it is also sweeping.
    // With inject set, a clear and a write are applied mid-sweep and must be ignored.
    task automatic sweep_check(input string name, input bit inject, input bit b_sweeping);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            sb_push({name, "_rdy"}, 32'(i == 32));
            sb_push({name, "_rdyb"}, b_sweeping ? 32'(i >= 24) : 32'd1);
            sb_push({name, "_rd0"}, 32'd0);
            sb_push({name, "_rd1"}, 32'd0);
            sb_pop(32'(ready));
            sb_pop(32'(b_ready));
            sb_pop(r_data[31:0]);
            sb_pop(r_data[63:32]);
            if (inject) begin
                if (i == 5)  clear = 1'b1;
                if (i == 6)  clear = 1'b0;
                if (i == 10) begin
                    w_en   = 1'b1;
                    w_addr = 5'd4;
                    w_data = 32'h0000_0099;
                end
                if (i == 11) w_en = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear    = 1'b0;
        w_en     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        r_addr   = '0;
        b_clear  = 1'b0;
        b_w_en   = 1'b0;
        b_w_addr = '0;
        b_w_data = '0;
        b_r_addr = '0;

        // Reset state.
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_push("rst_rdy", 32'd0);
        sb_push("rst_rdyb", 32'd0);
        sb_push("rst_rd0", 32'd0);
        sb_push("rst_rd1", 32'd0);
        sb_pop(32'(ready));
        sb_pop(32'(b_ready));
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);

        // Sweep after reset, reading entries 5 and 31.
        r_addr = {5'd31, 5'd5};
        rst    = 1'b0;
        sweep_check("sweep", 1'b0, 1'b1);

        // Write/read with the zero register.
        w_en   = 1'b1;
        w_addr = 5'd7;
        w_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        w_addr = 5'd0;
        w_data = 32'h1234_5678;
        @(posedge clk); #1;
        w_en   = 1'b0;
        r_addr = {5'd0, 5'd7};
        #1;
        sb_push("wr_addr7", 32'hDEAD_BEEF);
        sb_push("wr_addr0", 32'd0);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);

        // Same-cycle write/read of entry 9.
        w_en   = 1'b1;
        w_addr = 5'd9;
        w_data = 32'h0000_0001;
        @(posedge clk); #1;
        w_data = 32'hA5A5_A5A5;
        r_addr = {5'd7, 5'd9};
        #1;
        sb_push("byp_same", Bypass ? 32'hA5A5_A5A5 : 32'h0000_0001);
        sb_push("byp_other", 32'hDEAD_BEEF);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);
        @(posedge clk); #1;
        w_en   = 1'b0;
        r_addr = {5'd9, 5'd9};
        #1;
        sb_push("byp_next_p0", 32'hA5A5_A5A5);
        sb_push("byp_next_p1", 32'hA5A5_A5A5);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);

        // A write to entry 0 is dropped and never forwarded.
        w_en   = 1'b1;
        w_addr = 5'd0;
        w_data = 32'hFFFF_FFFF;
        r_addr = {5'd9, 5'd0};
        #1;
        sb_push("zero_fwd", 32'd0);
        sb_push("zero_other", 32'hA5A5_A5A5);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);
        @(posedge clk); #1;
        w_en = 1'b0;
        #1;
        sb_push("zero_after", 32'd0);
        sb_pop(r_data[31:0]);

        // Clear colliding with a write to entry 3.
        w_en   = 1'b1;
        w_addr = 5'd3;
        w_data = 32'h0000_0055;
        @(posedge clk); #1;
        w_data = 32'h0000_0077;
        clear  = 1'b1;
        r_addr = {5'd4, 5'd3};
        #1;
        sb_push("clr_rdy_pre", 32'd1);
        sb_push("clr_rd_pre", 32'h0000_0055);
        sb_pop(32'(ready));
        sb_pop(r_data[31:0]);
        @(posedge clk); #1;
        clear = 1'b0;
        w_en  = 1'b0;
        sweep_check("clrsweep", 1'b1, 1'b0);
        sb_push("clr_addr3", 32'd0);
        sb_push("clr_addr4", 32'd0);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);
        r_addr = {5'd9, 5'd7};
        #1;
        sb_push("clr_addr7", 32'd0);
        sb_push("clr_addr9", 32'd0);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);

        // Asynchronous reset from READY takes effect without a clock edge.
        w_en   = 1'b1;
        w_addr = 5'd12;
        w_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        w_en   = 1'b0;
        r_addr = {5'd12, 5'd12};
        #1;
        sb_push("pre_rst_p0", 32'hCAFE_F00D);
        sb_push("pre_rst_p1", 32'hCAFE_F00D);
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);
        #2;
        rst = 1'b1;
        #1;
        sb_push("arst_rdy", 32'd0);
        sb_push("arst_rd0", 32'd0);
        sb_push("arst_rd1", 32'd0);
        sb_push("arst_rdyb", 32'd0);
        sb_pop(32'(ready));
        sb_pop(r_data[31:0]);
        sb_pop(r_data[63:32]);
        sb_pop(32'(b_ready));
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset again at sweep cycle 10; a full fresh sweep must follow.
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb_push("mid_rst_rdy", 32'd0);
        sb_pop(32'(ready));
        @(posedge clk); #1;
        rst = 1'b0;
        sweep_check("rsweep", 1'b0, 1'b1);

        // Non-power-of-two instance: out-of-range write, last entry, zero register.
        b_w_en   = 1'b1;
        b_w_addr = 5'd30;
        b_w_data = 32'h0000_00FF;
        b_r_addr = {5'd0, 5'd23, 5'd30};
        #1;
        sb_push("b_oor_fwd", 32'd0);
        sb_pop(b_r_data[31:0]);
        @(posedge clk); #1;
        b_w_addr = 5'd23;
        b_w_data = 32'h0000_00AB;
        @(posedge clk); #1;
        b_w_addr = 5'd0;
        b_w_data = 32'h0000_00CD;
        @(posedge clk); #1;
        b_w_en = 1'b0;
        #1;
        sb_push("b_addr30", 32'd0);
        sb_push("b_addr23", 32'h0000_00AB);
        sb_push("b_addr0", 32'd0);
        sb_pop(b_r_data[31:0]);
        sb_pop(b_r_data[63:32]);
        sb_pop(b_r_data[95:64]);

        // Nothing may be left unchecked in the scoreboard.
        check_val("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
